// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the execute-stage ALU.
// Operation codes, handshake FSM states and multiply/divide selector.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULU = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;

  // ALUop from the main decoder into the ALU-control decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
// Divider datapath present only when ALU_EXEC_DIV_EN is defined.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             go;

`ifdef ALU_EXEC_DIV_EN
  md_op_t           op_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_trial;

  assign go = start;
`else
  assign go = start && (op == MD_MUL);
`endif

  // acc_hi:acc_lo is the product register (mul) or remainder:quotient (div)
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_EXEC_DIV_EN
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift[WIDTH-1:0] - operand_b;
    if (op_q == MD_DIV) begin
      if (div_shift >= {1'b0, operand_b}) begin
        hi_next = div_trial;
        lo_next = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (go) begin
      busy      <= 1'b1;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= a;
      operand_b <= b;
`ifdef ALU_EXEC_DIV_EN
      op_q      <= op;
`endif
    end else if (busy) begin
      acc_hi <= hi_next;
      acc_lo <= lo_next;
      cnt    <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

  // lo/hi carry the value being written by the final step, valid while done is high
  assign done = busy && (cnt == CNT_W'(WIDTH - 1));
  assign lo   = lo_next;
  assign hi   = hi_next;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith plus iterative MULU/DIVU behind valid/ready.
// Define ALU_EXEC_DIV_EN to build the divider; otherwise code 1001 reports illegal.
//
// state   | meaning
// ST_IDLE | ready for a request
// ST_BUSY | multiply/divide iterating
// ST_DONE | result presented, waiting for out_ready
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             is_md;
  logic             legal;
  logic             md_start;
  logic             md_done;
  md_op_t           md_op;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_valid  = (state == ST_DONE);
    accept     = in_valid && in_ready;
    simple_res = '0;
    legal      = 1'b1;
    is_md      = 1'b0;
    md_op      = MD_MUL;
    case (alu_ctrl)
      ALU_AND:  simple_res = a & b;
      ALU_OR:   simple_res = a | b;
      ALU_ADD:  simple_res = a + b;
      ALU_SUB:  simple_res = a - b;
      ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MULU: is_md = 1'b1;
`ifdef ALU_EXEC_DIV_EN
      ALU_DIVU: begin
        is_md = 1'b1;
        md_op = MD_DIV;
      end
`endif
      default:  legal = 1'b0;
    endcase
    md_start   = accept && is_md;
    next_state = state;
    case (state)
      ST_IDLE: if (accept)    next_state = is_md ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done)   next_state = ST_DONE;
      ST_DONE: if (out_ready) next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // Illegal codes leave simple_res at zero, so zero=1 falls out naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_md) begin
      result    <= simple_res;
      result_hi <= '0;
      zero      <= (simple_res == '0);
      illegal   <= !legal;
    end else if ((state == ST_BUSY) && md_done) begin
      result    <= md_lo;
      result_hi <= md_hi;
      zero      <= (md_lo == '0);
      illegal   <= 1'b0;
    end
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit with hand-written multi-cycle sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [3:0] c, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] r, input logic [31:0] h,
                              input logic z, input logic il, input int l);
    vec_t v;
    v.name = n; v.ctrl = c; v.va = x; v.vb = y;
    v.res = r; v.hi = h; v.zero = z; v.ill = il; v.lat = l;
    return v;
  endfunction

  // Waits for in_ready, issues one request, returns edges from accept to out_valid.
  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    alu_ctrl = c; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    vecs.push_back(mk("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 0, 1));
    vecs.push_back(mk("sub_zero", 4'b0110, 32'd5,         32'd5,         32'h0,         0, 1, 0, 1));
    vecs.push_back(mk("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 1));
    vecs.push_back(mk("slt_swap", 4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         0, 1, 0, 1));
    vecs.push_back(mk("and",      4'b0000, 32'hF0F0,      32'h0FF0,      32'h00F0,      0, 0, 0, 1));
    vecs.push_back(mk("or",       4'b0001, 32'hF0F0,      32'h0FF0,      32'hFFF0,      0, 0, 0, 1));
    vecs.push_back(mk("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 1, 0, 1));
    vecs.push_back(mk("sub_wrap", 4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 0, 0, 0, 1));
    vecs.push_back(mk("ill_1111", 4'b1111, 32'h123,       32'h4,         32'h0,         0, 1, 1, 1));
    vecs.push_back(mk("ill_0011", 4'b0011, 32'h55,        32'h66,        32'h0,         0, 1, 1, 1));
    vecs.push_back(mk("mulu",     4'b1000, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 32'h1, 0, 0, 33));
    vecs.push_back(mk("mulu_hi",  4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1, 1, 0, 33));
`ifdef ALU_EXEC_DIV_EN
    vecs.push_back(mk("divu",     4'b1001, 32'd100,       32'd7,         32'd14,        32'd2, 0, 0, 33));
    vecs.push_back(mk("divu_b0",  4'b1001, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9, 0, 0, 33));
`else
    vecs.push_back(mk("divu_ill", 4'b1001, 32'd100,       32'd7,         32'h0,         32'h0, 1, 1, 1));
`endif

    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; a = '0; b = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.in_ready",  in_ready,  1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result",    result,    0);
    chk("rst.result_hi", result_hi, 0);
    chk("rst.zero",      zero,      0);
    chk("rst.illegal",   illegal,   0);

    foreach (vecs[i]) begin
      issue(vecs[i].ctrl, vecs[i].va, vecs[i].vb, lat);
      chk({vecs[i].name, ".lat"},      lat,       vecs[i].lat);
      chk({vecs[i].name, ".result"},   result,    vecs[i].res);
      chk({vecs[i].name, ".hi"},       result_hi, vecs[i].hi);
      chk({vecs[i].name, ".zero"},     zero,      vecs[i].zero);
      chk({vecs[i].name, ".illegal"},  illegal,   vecs[i].ill);
      chk({vecs[i].name, ".in_ready"}, in_ready,  0);
      @(posedge clk); #1;
      chk({vecs[i].name, ".drop"},     out_valid, 0);
    end

    // MULU with operands and in_valid toggling while BUSY
    alu_ctrl = 4'b1000; a = 32'hFFFF_FFFF; b = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      a = $urandom; b = $urandom; alu_ctrl = 4'b0001;
      if (k == 5) chk("mul_busy.in_ready", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_tog.lat",    lat,       33);
    chk("mul_tog.result", result,    32'hFFFF_FFFE);
    chk("mul_tog.hi",     result_hi, 32'h1);
    @(posedge clk); #1;

    // Backpressure in DONE; an in_valid pulse must not be taken
    out_ready = 1'b0;
    issue(4'b0000, 32'h3C, 32'hF0, lat);
    chk("bp.lat", lat, 1);
    held = result;
    chk("bp.result", held, 32'h30);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; alu_ctrl = 4'b0001; a = 32'h1; b = 32'h2;
      @(posedge clk); #1;
      chk($sformatf("bp.valid%0d", k),  out_valid, 1);
      chk($sformatf("bp.hold%0d", k),   result,    held);
      chk($sformatf("bp.ready%0d", k),  in_ready,  0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.release_valid", out_valid, 0);
    chk("bp.release_ready", in_ready,  1);
    @(posedge clk); #1;
    chk("bp.no_overlap", out_valid, 0);

    // Reset ten cycles into a MULU
    alu_ctrl = 4'b1000; a = 32'h1234_5678; b = 32'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.in_ready",  in_ready,  1);
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.result",    result,    0);
    issue(4'b0000, 32'hF0F0, 32'h0FF0, lat);
    chk("rst_mid.and_lat", lat,    1);
    chk("rst_mid.and",     result, 32'h00F0);
    chk("rst_mid.and_hi",  result_hi, 0);
    @(posedge clk); #1;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mid.no_stale", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution unit that consumes the 4-bit ALU control code produced by the ALU-control decoder and performs the operation on two operands.
- Handles single-cycle logic/arithmetic and iterative multiply/divide behind a valid/ready handshake.
- Sits in the execute stage; a stall controller holds the pipeline while `in_ready` is low.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- alu_ctrl  input  4  operation code.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or immediate).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  primary result; for MULU this is the low word, for DIVU the quotient.
- result_hi  output  WIDTH  MULU high word, DIVU remainder; 0 for other operations.
- zero  output  1  asserted when result equals 0.
- illegal  output  1  unsupported code; qualified by out_valid.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high; no asynchronous paths.
- Reset values: state is IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, zero=0, illegal=0.
- Reset mid-operation: any operation in flight is abandoned and the unit returns to reset values on the next edge. No partial result is ever emitted.
- Operation codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 1000 MULU
  - 1001 DIVU
  - Any other code is illegal.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept when in_valid&&in_ready, and latch alu_ctrl, a and b.
    - Simple or illegal code: go to DONE; result is registered on the same edge.
    - MULU or DIVU: go to BUSY and clear the counter.
  - BUSY: in_ready=0. One shift-add (MULU) or restoring-subtract (DIVU) step per cycle.
    - After exactly WIDTH steps, go to DONE.
    - Input changes during BUSY are ignored, because the operands were latched at accept.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready=1.
    - On that edge go to IDLE and drop out_valid.
    - No new request is accepted on the same edge; there is no overlap.
- Latency, from the accept edge to out_valid high:
  - Simple ops: 1 cycle.
  - MULU and DIVU: WIDTH+1 cycles.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
  - SLT: result = 1 if a < b as signed, else 0.
  - MULU: full unsigned 2*WIDTH product, returned as {result_hi, result}.
  - DIVU, b=0: quotient = all ones, remainder = a. Still takes WIDTH+1 cycles.
- Illegal code: result=0, result_hi=0, zero=1, illegal=1, 1-cycle latency.
- zero is computed from the final registered result.
- out_ready held high: throughput is one op per 2 cycles for simple ops.

Optional Feature:
- Macro: ALU_EXEC_DIV_EN.
- Defined: DIVU is implemented as described above.
- Undefined: the divider datapath is removed, and code 1001 is treated as illegal (1-cycle latency, illegal=1).
- MULU behaviour is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - The operation-code localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MULU, ALU_DIVU.
  - State encodings ST_IDLE, ST_BUSY, ST_DONE.
  - The ALUop encodings shared with the decoder.
- One sub-module: alu_iter_muldiv.
  - Contains the iterative multiply/divide datapath and the counter.
  - Interface: start, op, a, b in; done, lo, hi out.
  - The top level holds the handshake FSM and the single-cycle ops.

Test Plan:
- Reset and simple op: hold rst 2 cycles, then ADD a=0x7FFFFFFF, b=1. Expect out_valid exactly 1 cycle after accept, result=0x80000000, zero=0. Then SUB 5-5 gives result=0, zero=1.
- SLT: a=0xFFFFFFFF (-1), b=1 gives result=1; with operands swapped, result=0.
- MULU: a=0xFFFFFFFF, b=2. Expect out_valid 33 cycles after accept, result=0xFFFFFFFE, result_hi=1. Toggle a and b during BUSY; the result must not change.
- DIVU: 100/7 gives result=14, result_hi=2 at 33 cycles. 9/0 gives result=0xFFFFFFFF, result_hi=9. With ALU_EXEC_DIV_EN undefined, code 1001 gives illegal=1 after 1 cycle.
- Backpressure and illegal code: hold out_ready=0 for 5 cycles in DONE. Outputs stay stable, in_ready=0, and an in_valid pulse is not accepted. Code 1111 gives result=0, illegal=1.
- Reset mid-MULU: assert rst 10 cycles into BUSY. Next cycle in_ready=1 and out_valid=0. A following AND 0xF0F0&0x0FF0 gives 0x00F0.
